operand_sequencer: RTL and testbench
====================================

OPERAND_SEQUENCER -- requirements
Module: operand_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand word width in bits.
REQ-002 SHALL have parameter TIMEOUT, default 255, maximum cycles to wait for a read or multiply to complete (range 1-255).
REQ-003 SHALL have port clk  input  1  single clock; all logic updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  request one complex-multiply transaction; sampled only in IDLE.
REQ-006 SHALL have port busy  output  1  high in every state except IDLE.
REQ-007 SHALL have port rd_run  output  1  one-cycle run pulse to the read state machine.
REQ-008 SHALL have port rd_read  input  1  read strobe from the read state machine; rd_data is valid while it is high.
REQ-009 SHALL have port rd_data  input  WIDTH  operand word being read.
REQ-010 SHALL have port rd_done  input  1  one-cycle completion pulse from the read state machine.
REQ-011 SHALL have ports a_re, a_im, b_re, b_im  output  WIDTH each  latched operands, in read order a_re, a_im, b_re, b_im.
REQ-012 SHALL have port mult_start  output  1  one-cycle start pulse to the multiplier.
REQ-013 SHALL have port mult_done  input  1  multiplier completion pulse.
REQ-014 SHALL have port result_valid  output  1  transaction complete; held until result_ack.
REQ-015 SHALL have port result_ack  input  1  consumer acknowledge.
REQ-016 SHALL have port err  output  1  sticky error flag; cleared only by start accepted in IDLE, or by reset.

Function
REQ-017 SHALL use states IDLE, ISSUE, WAIT_RD, MULT, WAIT_MULT, HOLD.
- IDLE: on start=1, go to ISSUE, clear err, and set word count cnt to 0.
- ISSUE: assert rd_run for exactly one cycle, clear the captured flag and the timer, then go to WAIT_RD.
- WAIT_RD: the first rd_read=1 latches rd_data into operand[cnt] and sets the captured flag.
- WAIT_RD: further rd_read pulses in the same read are ignored (no overwrite).
- WAIT_RD, on rd_done=1 with the captured flag set: if cnt=3, go to MULT; otherwise increment cnt and go to ISSUE.
REQ-018 SHALL treat rd_done=1 without the captured flag set as an error: set err and return to IDLE.
REQ-019 SHALL, when rd_read and rd_done are high in the same cycle, capture the data and then act on rd_done as captured.
REQ-020 SHALL, in MULT, assert mult_start for exactly one cycle, clear the timer, and go to WAIT_MULT.
REQ-021 SHALL, in WAIT_MULT, go to HOLD on mult_done=1.
REQ-022 SHALL, in HOLD, drive result_valid=1 and hold it until result_ack=1, then return to IDLE.
REQ-023 SHALL leave a result_ack that arrives in the first HOLD cycle free to exit on that cycle.
REQ-024 SHALL run an 8-bit timer in WAIT_RD and WAIT_MULT.
- The timer increments each cycle the awaited pulse is absent.
- When the timer reaches TIMEOUT: set err and go to IDLE; outputs are then as in REQ-028.
REQ-025 SHALL ignore start outside IDLE; no queuing.
REQ-026 SHALL ignore mult_done outside WAIT_MULT, and rd_read/rd_done outside WAIT_RD.
REQ-027 SHALL hold a_re..b_im stable from capture until overwritten by the next transaction; values persist through IDLE.
REQ-028 SHALL register all outputs; no combinational path from any input to any output.

Reset
REQ-029 SHALL, while reset_n=0, force state IDLE and drive busy, rd_run, mult_start, result_valid and err to 0.
REQ-030 SHALL, while reset_n=0, force a_re, a_im, b_re, b_im, cnt and the timer to 0.
REQ-031 SHALL abort any transaction in progress on reset assertion; no rd_run or mult_start pulse may be emitted during or on the first cycle after reset release.

Verification
REQ-032 SHALL cover the nominal case: start pulse; four reads returning 0x0003, 0x0004, 0x0005, 0xFFFE; mult_done 3 cycles after mult_start; result_ack 2 cycles after result_valid.
- Required response: exactly 4 rd_run pulses and 1 mult_start pulse; operands 3, 4, 5, 0xFFFE; result_valid high 2 cycles; then IDLE with busy=0.
REQ-033 SHALL cover a double strobe: rd_read high for two cycles with data 0x1111 then 0x2222.
- Required response: the operand equals 0x1111.
REQ-034 SHALL cover a missing handshake: rd_done never arrives after the first rd_run.
- Required response: err=1 and busy=0 exactly TIMEOUT cycles after entering WAIT_RD; no further rd_run.
REQ-035 SHALL cover a done without data: rd_done with no preceding rd_read.
- Required response: err=1 the next cycle, state IDLE; a following start clears err and completes normally.
REQ-036 SHALL cover reset mid-operation: reset_n pulsed low during WAIT_MULT.
- Required response: all outputs 0 immediately; a late mult_done after reset causes no result_valid.
REQ-037 SHALL bind these assertions in the bench:
- rd_run |=> !rd_run
- mult_start |=> !mult_start
- result_valid && !result_ack |=> result_valid
- rd_run only while busy

Source files
------------

// File: rtl/operand_sequencer.sv
// Sequences four operand reads and one multiply for a complex-multiply transaction.
// Every output is a flop loaded from next-state values, so no input reaches an output combinationally.
module operand_sequencer #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  output logic             busy,
  output logic             rd_run,
  input  logic             rd_read,
  input  logic [WIDTH-1:0] rd_data,
  input  logic             rd_done,
  output logic [WIDTH-1:0] a_re,
  output logic [WIDTH-1:0] a_im,
  output logic [WIDTH-1:0] b_re,
  output logic [WIDTH-1:0] b_im,
  output logic             mult_start,
  input  logic             mult_done,
  output logic             result_valid,
  input  logic             result_ack,
  output logic             err
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RD, MULT, WAIT_MULT, HOLD} state_t;

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  state_t                  state, state_nx;
  logic [1:0]              cnt, cnt_nx;
  logic                    captured, captured_nx;
  logic [7:0]              timer, timer_nx;
  logic                    err_nx;
  logic                    cap_en;
  logic [3:0][WIDTH-1:0]   opnd;

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    captured_nx = captured;
    timer_nx    = timer;
    err_nx      = err;
    cap_en      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = ISSUE;
          err_nx   = 1'b0;
          cnt_nx   = 2'd0;
        end
      end
      ISSUE: begin
        captured_nx = 1'b0;
        timer_nx    = 8'd0;
        state_nx    = WAIT_RD;
      end
      WAIT_RD: begin
        // Only the first strobe of a read is kept; a strobe coinciding with done still counts.
        cap_en = rd_read && !captured;
        if (cap_en) captured_nx = 1'b1;
        if (rd_done) begin
          if (captured || rd_read) begin
            if (cnt == 2'd3) begin
              state_nx = MULT;
            end else begin
              cnt_nx   = cnt + 2'd1;
              state_nx = ISSUE;
            end
          end else begin
            err_nx   = 1'b1;
            state_nx = IDLE;
          end
        end else begin
          timer_nx = timer + 8'd1;
          if (timer_nx == TMO) begin
            err_nx   = 1'b1;
            state_nx = IDLE;
          end
        end
      end
      MULT: begin
        timer_nx = 8'd0;
        state_nx = WAIT_MULT;
      end
      WAIT_MULT: begin
        if (mult_done) begin
          state_nx = HOLD;
        end else begin
          timer_nx = timer + 8'd1;
          if (timer_nx == TMO) begin
            err_nx   = 1'b1;
            state_nx = IDLE;
          end
        end
      end
      HOLD: begin
        if (result_ack) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= 2'd0;
      captured     <= 1'b0;
      timer        <= 8'd0;
      err          <= 1'b0;
      busy         <= 1'b0;
      rd_run       <= 1'b0;
      mult_start   <= 1'b0;
      result_valid <= 1'b0;
      opnd         <= '0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      captured     <= captured_nx;
      timer        <= timer_nx;
      err          <= err_nx;
      busy         <= (state_nx != IDLE);
      rd_run       <= (state_nx == ISSUE);
      mult_start   <= (state_nx == MULT);
      result_valid <= (state_nx == HOLD);
      if (cap_en) opnd[cnt] <= rd_data;
    end
  end

  assign a_re = opnd[0];
  assign a_im = opnd[1];
  assign b_re = opnd[2];
  assign b_im = opnd[3];

endmodule

// File: tb/tb_operand_sequencer.sv
// Bench for operand_sequencer: directed scenarios plus randomized read/multiply responders,
// all outputs compared every cycle against a phase-level reference model.
module tb_operand_sequencer;
  localparam int W   = 16;
  localparam int TMO = 20;

  logic         clk = 1'b0, reset_n = 1'b0, start = 1'b0;
  logic         rd_read = 1'b0, rd_done = 1'b0, mult_done = 1'b0, result_ack = 1'b0;
  logic [W-1:0] rd_data = '0;
  logic         busy, rd_run, mult_start, result_valid, err;
  logic [W-1:0] a_re, a_im, b_re, b_im;

  int tests = 0, fails = 0;
  int n_rd_run = 0, n_mstart = 0, n_valid = 0;

  operand_sequencer #(.WIDTH(W), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .rd_run(rd_run),
    .rd_read(rd_read), .rd_data(rd_data), .rd_done(rd_done),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .mult_start(mult_start), .mult_done(mult_done),
    .result_valid(result_valid), .result_ack(result_ack), .err(err)
  );

  always #5 clk = ~clk;

  // Reference model: transaction phase, operand store, word index, capture flag, wait counter.
  typedef enum int {M_IDLE, M_ISSUE, M_RD, M_MULT, M_WMULT, M_HOLD} mphase_t;
  mphase_t      ph = M_IDLE;
  logic [W-1:0] ops [4];
  int           w = 0, waited = 0;
  bit           got = 0, m_err = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ph <= M_IDLE;
      for (int i = 0; i < 4; i++) ops[i] <= '0;
      w <= 0; got <= 0; waited <= 0; m_err <= 0;
    end else begin
      case (ph)
        M_IDLE: if (start) begin ph <= M_ISSUE; m_err <= 0; w <= 0; end
        M_ISSUE: begin got <= 0; waited <= 0; ph <= M_RD; end
        M_RD: begin
          if (rd_read && !got) begin ops[w] <= rd_data; got <= 1; end
          if (rd_done) begin
            if (got || rd_read) begin
              if (w == 3) ph <= M_MULT;
              else begin w <= w + 1; ph <= M_ISSUE; end
            end else begin m_err <= 1; ph <= M_IDLE; end
          end else begin
            waited <= waited + 1;
            if (waited + 1 >= TMO) begin m_err <= 1; ph <= M_IDLE; end
          end
        end
        M_MULT: begin waited <= 0; ph <= M_WMULT; end
        M_WMULT: begin
          if (mult_done) ph <= M_HOLD;
          else begin
            waited <= waited + 1;
            if (waited + 1 >= TMO) begin m_err <= 1; ph <= M_IDLE; end
          end
        end
        M_HOLD: if (result_ack) ph <= M_IDLE;
        default: ph <= M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    logic [4:0] exp_ctl, got_ctl;
    exp_ctl = {ph != M_IDLE, ph == M_ISSUE, ph == M_MULT, ph == M_HOLD, m_err};
    got_ctl = {busy, rd_run, mult_start, result_valid, err};
    tests++;
    if (got_ctl !== exp_ctl || a_re !== ops[0] || a_im !== ops[1] || b_re !== ops[2] || b_im !== ops[3]) begin
      fails++;
      $display("FAIL cycle_model t=%0t ctl(busy,run,mst,val,err) got %b exp %b ops got %h %h %h %h exp %h %h %h %h",
               $time, got_ctl, exp_ctl, a_re, a_im, b_re, b_im, ops[0], ops[1], ops[2], ops[3]);
    end
    if (rd_run) n_rd_run++;
    if (mult_start) n_mstart++;
    if (result_valid) n_valid++;
  end

  a_run_pulse: assert property (@(posedge clk) disable iff (!reset_n) rd_run |=> !rd_run)
    else begin fails++; $display("FAIL assert_rd_run_pulse t=%0t", $time); end
  a_mst_pulse: assert property (@(posedge clk) disable iff (!reset_n) mult_start |=> !mult_start)
    else begin fails++; $display("FAIL assert_mult_start_pulse t=%0t", $time); end
  a_valid_hold: assert property (@(posedge clk) disable iff (!reset_n) result_valid && !result_ack |=> result_valid)
    else begin fails++; $display("FAIL assert_valid_hold t=%0t", $time); end
  a_run_busy: assert property (@(posedge clk) disable iff (!reset_n) rd_run |-> busy)
    else begin fails++; $display("FAIL assert_run_while_busy t=%0t", $time); end

  task automatic step();
    @(negedge clk); #2;
  endtask

  task automatic chk(input string name, input logic [31:0] got_v, input logic [31:0] exp_v);
    tests++;
    if (got_v !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got_v, exp_v);
    end
  endtask

  function automatic bit sig(input int sel);
    case (sel)
      0: return rd_run;
      1: return mult_start;
      default: return result_valid;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int bound);
    bit ok = 0;
    for (int i = 0; i < bound; i++) begin
      if (sig(sel)) begin ok = 1; break; end
      step();
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL wait_timeout sel=%0d: got no pulse expected one within %0d cycles", sel, bound);
    end
  endtask

  task automatic start_txn();
    start = 1; step(); start = 0;
  endtask

  task automatic read_word(input logic [W-1:0] d, input bit twice, input logic [W-1:0] d2);
    wait_for(0, 40);
    step();
    rd_read = 1; rd_data = d; step();
    if (twice) begin rd_data = d2; step(); end
    rd_read = 0; rd_done = 1; step();
    rd_done = 0;
  endtask

  task automatic do_mult(input int dly);
    wait_for(1, 40);
    step();
    repeat (dly - 1) step();
    mult_done = 1; step(); mult_done = 0;
  endtask

  task automatic do_ack(input int n);
    wait_for(2, 40);
    repeat (n - 1) step();
    result_ack = 1; step(); result_ack = 0;
  endtask

  initial begin
    int b_run, b_mst, b_val, n;
    logic [W-1:0] rv [4];
    int rp_k, rd_at, rd_len, done_at, rp_len, mp_k, mdone_at, mp_len, mode;

    // reset state
    repeat (3) step();
    chk("reset_busy", 32'(busy), 0);
    chk("reset_err", 32'(err), 0);
    chk("reset_a_re", 32'(a_re), 0);
    reset_n = 1; step();

    // nominal transaction
    b_run = n_rd_run; b_mst = n_mstart; b_val = n_valid;
    start_txn();
    read_word(16'h0003, 0, '0);
    read_word(16'h0004, 0, '0);
    read_word(16'h0005, 0, '0);
    read_word(16'hFFFE, 0, '0);
    do_mult(3);
    do_ack(2);
    chk("nom_rd_runs", 32'(n_rd_run - b_run), 4);
    chk("nom_mult_starts", 32'(n_mstart - b_mst), 1);
    chk("nom_valid_cycles", 32'(n_valid - b_val), 2);
    chk("nom_busy_after", 32'(busy), 0);
    chk("nom_err", 32'(err), 0);
    chk("nom_a_re", 32'(a_re), 32'h0003);
    chk("nom_a_im", 32'(a_im), 32'h0004);
    chk("nom_b_re", 32'(b_re), 32'h0005);
    chk("nom_b_im", 32'(b_im), 32'hFFFE);
    step();
    chk("nom_ops_persist", 32'(b_im), 32'hFFFE);

    // double strobe keeps the first word
    start_txn();
    read_word(16'h1111, 1, 16'h2222);
    chk("dbl_a_re", 32'(a_re), 32'h1111);
    read_word(16'h0A0A, 0, '0);
    read_word(16'h0B0B, 0, '0);
    read_word(16'h0C0C, 0, '0);
    do_mult(2);
    do_ack(1);
    chk("dbl_a_re_final", 32'(a_re), 32'h1111);

    // missing handshake: timeout exactly TMO cycles after entering WAIT_RD
    b_run = n_rd_run;
    start_txn();
    wait_for(0, 10);
    step();
    n = 0;
    while (busy && n < TMO + 5) begin step(); n++; end
    chk("tmo_cycles", 32'(n), TMO);
    chk("tmo_err", 32'(err), 1);
    repeat (5) step();
    chk("tmo_rd_runs", 32'(n_rd_run - b_run), 1);

    // done without data, then a clean transaction clears err
    start_txn();
    wait_for(0, 10);
    step();
    rd_done = 1; step(); rd_done = 0;
    chk("nodata_err", 32'(err), 1);
    chk("nodata_busy", 32'(busy), 0);
    start_txn();
    chk("restart_err_clear", 32'(err), 0);
    for (int i = 0; i < 4; i++) begin
      rv[i] = W'($urandom);
      read_word(rv[i], 0, '0);
    end
    do_mult(1);
    do_ack(1);
    chk("restart_a_re", 32'(a_re), 32'(rv[0]));
    chk("restart_b_im", 32'(b_im), 32'(rv[3]));
    chk("restart_busy", 32'(busy), 0);

    // reset during WAIT_MULT, then a late mult_done
    start_txn();
    for (int i = 0; i < 4; i++) read_word(W'(16'h0100 + i), 0, '0);
    wait_for(1, 20);
    step(); step();
    reset_n = 0; #1;
    chk("rst_outputs", 32'({busy, rd_run, mult_start, result_valid, err}), 0);
    chk("rst_b_im", 32'(b_im), 0);
    b_val = n_valid;
    step(); reset_n = 1; step();
    mult_done = 1; step(); mult_done = 0;
    repeat (3) step();
    chk("rst_no_valid", 32'(n_valid - b_val), 0);
    chk("rst_busy", 32'(busy), 0);

    // randomized responders
    rp_k = -1; mp_k = -1; rd_at = 0; rd_len = 0; done_at = -1; rp_len = 0; mdone_at = -1; mp_len = 0;
    for (int it = 0; it < 3000; it++) begin
      rd_read = 0; rd_done = 0; mult_done = 0;
      rd_data = W'($urandom);
      if (rp_k >= 0) begin
        if (rp_k >= rd_at && rp_k < rd_at + rd_len) rd_read = 1;
        if (rp_k == done_at) rd_done = 1;
        rp_k++;
        if (rp_k > rp_len) rp_k = -1;
      end
      if (rd_run) begin
        rd_read = 1'($urandom); rd_done = 1'($urandom);
        mode = int'($urandom_range(0, 11));
        rd_at = int'($urandom_range(0, 2));
        rd_len = int'($urandom_range(1, 2));
        if (mode == 0) begin rd_len = 0; done_at = -1; rp_len = TMO + 2; end
        else if (mode == 1) begin rd_len = 0; done_at = rd_at; rp_len = done_at; end
        else begin done_at = rd_at + rd_len - 1 + int'($urandom_range(0, 1)); rp_len = done_at; end
        rp_k = 0;
      end
      if (mp_k >= 0) begin
        if (mp_k == mdone_at) mult_done = 1;
        mp_k++;
        if (mp_k > mp_len) mp_k = -1;
      end else begin
        mult_done = ($urandom_range(0, 15) == 0);
      end
      if (mult_start) begin
        mdone_at = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 3));
        mp_len = (mdone_at < 0) ? TMO + 2 : mdone_at;
        mp_k = 0;
      end
      start = ($urandom_range(0, 5) == 0);
      result_ack = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 399) == 0) begin
        reset_n = 0; rp_k = -1; mp_k = -1;
        step();
        reset_n = 1;
      end
      step();
    end
    start = 0; rd_read = 0; rd_done = 0; mult_done = 0; result_ack = 0;
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
